// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: issues one program-memory read per instruction,
// holds the fetched word for execute under a valid/ready handshake and strobes
// the program counter once per captured instruction or taken jump.
module instr_fetch_unit #(
    parameter int ADDR_W  = 14,
    parameter int INSTR_W = 14
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               update_pc,
    input  logic               fetch_enable,
    input  logic               flush,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_valid,
    input  logic               instr_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [ADDR_W-1:0]  instr_addr_reg, instr_addr_next;
    logic               instr_valid_reg, instr_valid_next;
    logic               update_pc_next;

    // A request is in flight whenever we are waiting on memory, whether the
    // data will be used (FETCH) or thrown away after a jump (DRAIN).
    logic req_outstanding;
    assign req_outstanding = (state_reg == FETCH) || (state_reg == DRAIN);

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            instr_reg       <= '0;
            instr_addr_reg  <= '0;
            instr_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mem_req_reg     <= mem_req_next;
            mem_addr_reg    <= mem_addr_next;
            instr_reg       <= instr_next;
            instr_addr_reg  <= instr_addr_next;
            instr_valid_reg <= instr_valid_next;
        end
    end

    // Next-state and output decode; a flush overrides every state action so
    // a capture in the same cycle is dropped and the PC strobe fires only once.
    always_comb begin
        state_next       = state_reg;
        mem_req_next     = mem_req_reg;
        mem_addr_next    = mem_addr_reg;
        instr_next       = instr_reg;
        instr_addr_next  = instr_addr_reg;
        instr_valid_next = instr_valid_reg;
        update_pc_next   = 1'b0;

        if (flush) begin
            update_pc_next   = 1'b1;
            instr_valid_next = 1'b0;
            if (req_outstanding && !mem_valid) begin
                // Memory still owes us a word: keep the request up and eat it.
                state_next   = DRAIN;
                mem_req_next = 1'b1;
            end else begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fetch_enable) begin
                        mem_req_next  = 1'b1;
                        mem_addr_next = pc;
                        state_next    = FETCH;
                    end
                end
                FETCH: begin
                    // Completes regardless of fetch_enable.
                    if (mem_valid) begin
                        instr_next       = mem_rdata;
                        instr_addr_next  = mem_addr_reg;
                        instr_valid_next = 1'b1;
                        mem_req_next     = 1'b0;
                        update_pc_next   = 1'b1;
                        state_next       = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid_next = 1'b0;
                        if (fetch_enable) begin
                            // pc already advanced on the capture edge.
                            mem_req_next  = 1'b1;
                            mem_addr_next = pc;
                            state_next    = FETCH;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_valid) begin
                        mem_req_next = 1'b0;
                        state_next   = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // The PC strobe is combinational, so it must be masked while in reset.
    assign update_pc   = update_pc_next & ~reset;
    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign instr       = instr_reg;
    assign instr_addr  = instr_addr_reg;
    assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, checked against a program-counter / memory / in-order
// delivery model of the fetch path.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 14;
    localparam int INSTR_W = 14;

    logic               clock = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  pc;
    logic               update_pc;
    logic               fetch_enable;
    logic               flush;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_addr;
    logic               instr_valid;
    logic               instr_ready;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .update_pc    (update_pc),
        .fetch_enable (fetch_enable),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .instr        (instr),
        .instr_addr   (instr_addr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready)
    );

    always #5 clock = ~clock;

    // Reference model state: program image, memory latency, expected stream.
    logic [INSTR_W-1:0] mem_img [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  exp_addr;     // address of the next instruction execute must see
    bit                 in_req;       // memory has accepted the current request
    bit                 discard;      // current request belongs to a flushed path
    int                 wait_left;
    int                 next_wait;
    int                 n_cmp, n_bad, n_deliv, n_upd, n_req_cyc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, answer memory, check, advance the model.
    task automatic step(input logic fe, input logic fl, input logic rdy);
        logic               s_req, s_mv, s_ivalid, s_upd;
        logic [ADDR_W-1:0]  s_maddr, s_iaddr;
        logic [INSTR_W-1:0] s_instr;
        fetch_enable = fe;
        flush        = fl;
        instr_ready  = rdy;
        if (mem_req && !in_req) begin
            in_req    = 1'b1;
            wait_left = next_wait;
        end
        mem_valid = mem_req && in_req && (wait_left == 0);
        mem_rdata = mem_valid ? mem_img[mem_addr] : INSTR_W'($urandom);
        #1;
        // PC moves on a jump, or once per useful memory return.
        check_eq("update_pc", update_pc, fl || (mem_valid && !discard));
        if (instr_valid) check_eq("no_req_while_holding", mem_req, 1'b0);
        s_req = mem_req; s_mv = mem_valid; s_ivalid = instr_valid; s_upd = update_pc;
        s_maddr = mem_addr; s_iaddr = instr_addr; s_instr = instr;
        if (update_pc) n_upd++;
        if (mem_req) n_req_cyc++;

        @(posedge clock);
        #1;
        if (s_upd) pc = fl ? jump_target : pc + 1'b1;
        if (fl) begin
            discard  = s_req && !s_mv;
            exp_addr = jump_target;
        end else if (s_req && s_mv) begin
            discard = 1'b0;
        end
        if (s_req && s_mv) in_req = 1'b0;
        else if (s_req) wait_left--;

        if (s_ivalid && rdy && !fl) begin
            check_eq("deliver_addr", s_iaddr, exp_addr);
            check_eq("deliver_data", s_instr, mem_img[exp_addr]);
            $display("deliver #%0d addr=0x%04h instr=0x%04h", n_deliv, s_iaddr, s_instr);
            exp_addr = exp_addr + 1'b1;
            n_deliv++;
        end
        if (fl) check_eq("flush_kills_valid", instr_valid, 1'b0);
        if (s_req && !s_mv) begin
            check_eq("req_held", mem_req, 1'b1);
            check_eq("addr_stable", mem_addr, s_maddr);
        end else if (s_req && s_mv) begin
            check_eq("req_drop_after_data", mem_req, 1'b0);
        end else if (mem_req) begin
            check_eq("new_req_addr", mem_addr, exp_addr);
        end
        if (s_ivalid && !rdy && !fl) begin
            check_eq("hold_valid", instr_valid, 1'b1);
            check_eq("hold_instr", instr, s_instr);
            check_eq("hold_addr", instr_addr, s_iaddr);
        end
        mem_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_deliv = 0; n_upd = 0; n_req_cyc = 0;
        in_req = 1'b0; discard = 1'b0; wait_left = 0; next_wait = 0;
        exp_addr = '0; jump_target = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem_img[i] = INSTR_W'($urandom);
        mem_img[0] = 14'h2805;

        // Reset: outputs cleared, PC strobe masked even with flush/mem_valid high.
        reset = 1'b1; pc = '0; fetch_enable = 1'b1; flush = 1'b1; instr_ready = 1'b1;
        mem_valid = 1'b1; mem_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_instr_addr", instr_addr, 0);
        check_eq("rst_instr_valid", instr_valid, 1'b0);
        check_eq("rst_update_pc", update_pc, 1'b0);
        flush = 1'b0; mem_valid = 1'b0; reset = 1'b0;

        // Zero-wait streaming from 0x0000.
        n_upd = 0;
        step(1'b1, 1'b0, 1'b1);
        check_eq("c1_mem_req", mem_req, 1'b1);
        check_eq("c1_mem_addr", mem_addr, 0);
        step(1'b1, 1'b0, 1'b1);
        check_eq("c2_instr_valid", instr_valid, 1'b1);
        check_eq("c2_instr", instr, 14'h2805);
        check_eq("c2_instr_addr", instr_addr, 0);
        check_eq("c2_pc_advanced", pc, 1);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        check_eq("stream_deliveries", n_deliv, 3);
        check_eq("stream_upd_pulses", n_upd, 3);

        // Three wait states.
        next_wait = 3; n_upd = 0; n_req_cyc = 0;
        repeat (5) step(1'b1, 1'b0, 1'b0);
        check_eq("ws3_req_cycles", n_req_cyc, 4);
        check_eq("ws3_upd_pulses", n_upd, 1);
        check_eq("ws3_valid", instr_valid, 1'b1);
        check_eq("ws3_instr_addr", instr_addr, 3);

        // Execute stalls for 5 cycles.
        n_upd = 0; n_req_cyc = 0;
        repeat (5) step(1'b1, 1'b0, 1'b0);
        check_eq("stall_req_cycles", n_req_cyc, 0);
        check_eq("stall_upd_pulses", n_upd, 0);
        check_eq("stall_instr_addr", instr_addr, 3);
        step(1'b1, 1'b0, 1'b1);
        check_eq("resume_req", mem_req, 1'b1);
        check_eq("resume_addr", mem_addr, 4);

        // Flush two cycles before the memory answers.
        next_wait = 3;
        step(1'b1, 1'b0, 1'b1);
        jump_target = 14'h0123; n_upd = 0;
        step(1'b1, 1'b1, 1'b1);
        check_eq("drain_req_held", mem_req, 1'b1);
        next_wait = 0;
        repeat (2) step(1'b1, 1'b0, 1'b1);
        check_eq("drain_done_req", mem_req, 1'b0);
        check_eq("drain_no_valid", instr_valid, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_eq("jump_req", mem_req, 1'b1);
        check_eq("jump_addr", mem_addr, 14'h0123);
        check_eq("drain_upd_pulses", n_upd, 1);

        // Flush on the same cycle as the data return.
        jump_target = 14'h0200; n_upd = 0;
        step(1'b1, 1'b1, 1'b1);
        check_eq("flush_mv_upd", n_upd, 1);
        check_eq("flush_mv_idle_req", mem_req, 1'b0);
        check_eq("flush_mv_valid", instr_valid, 1'b0);
        next_wait = 2;
        step(1'b1, 1'b0, 1'b1);
        check_eq("flush_mv_next_addr", mem_addr, 14'h0200);

        // fetch_enable drops while the fetch is outstanding.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check_eq("fe_low_hold_valid", instr_valid, 1'b1);
        check_eq("fe_low_hold_addr", instr_addr, 14'h0200);
        step(1'b0, 1'b0, 1'b1);
        check_eq("fe_low_idle_req", mem_req, 1'b0);
        check_eq("fe_low_idle_valid", instr_valid, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("fe_low_stays_idle", mem_req, 1'b0);

        // Asynchronous reset in the middle of a fetch.
        next_wait = 5;
        repeat (2) step(1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_mem_req", mem_req, 1'b0);
        check_eq("arst_mem_addr", mem_addr, 0);
        check_eq("arst_instr", instr, 0);
        check_eq("arst_instr_valid", instr_valid, 1'b0);
        check_eq("arst_update_pc", update_pc, 1'b0);
        pc = '0; exp_addr = '0; in_req = 1'b0; discard = 1'b0; wait_left = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Randomized traffic.
        n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            jump_target = ADDR_W'($urandom);
            next_wait   = int'($urandom_range(0, 3));
            step(($urandom % 8) != 0, ($urandom % 15) == 0, ($urandom % 3) != 0);
        end
        check_eq("random_progress", n_deliv >= 200, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer for the RISC_8-bit core. It sits between the program counter and program memory. It issues one program-memory read per instruction at the current PC, holds the returned 14-bit instruction for the execute stage under a valid/ready handshake, and generates the `update_pc` strobe that advances or reloads the PC. Taken jumps from execute flush the fetch path, and the PC is reloaded in the same cycle.

## Interface
- `ADDR_W`, default 14: program address width; must match PC width.
- `INSTR_W`, default 14: instruction word width.

Ports:
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  ADDR_W  current PC value from the program counter.
- `update_pc`  out  1  combinational strobe to the program counter.
  - PC increments on this edge, or loads the jump address when execute also drives jump_enable.
- `fetch_enable`  in  1  core running; low inhibits new memory requests (halt/sleep).
- `flush`  in  1  from execute; asserted for one cycle together with jump_enable on a taken jump.
- `mem_req`  out  ADDR_W-independent 1  registered read request to program memory.
- `mem_addr`  out  ADDR_W  registered read address; stable while mem_req high.
- `mem_rdata`  in  INSTR_W  read data; sampled only when mem_valid high.
- `mem_valid`  in  1  read data valid; may be high in the first cycle mem_req is high (zero-wait).
- `instr`  out  INSTR_W  fetched instruction to execute.
- `instr_addr`  out  ADDR_W  address the instruction was fetched from.
- `instr_valid`  out  1  instr/instr_addr valid.
- `instr_ready`  in  1  execute accepts instr this cycle.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. Reset to IDLE.
- IDLE
  - if fetch_enable && !flush: mem_req<=1, mem_addr<=pc, go FETCH.
  - else stay.
- FETCH: mem_req and mem_addr held constant until mem_valid.
  - mem_valid && !flush: instr<=mem_rdata, instr_addr<=mem_addr, instr_valid<=1, mem_req<=0, update_pc=1, go HOLD.
  - Completion does not depend on fetch_enable; an outstanding request always completes.
- HOLD: instr_valid=1; instr/instr_addr stable.
  - instr_ready && fetch_enable: instr_valid<=0, mem_req<=1, mem_addr<=pc, go FETCH.
  - instr_ready && !fetch_enable: instr_valid<=0, go IDLE.
  - else stay.
- DRAIN: mem_req held until mem_valid; returned data discarded; then mem_req<=0, go IDLE.
- flush, from any state, has priority over everything above:
  - update_pc=1; instr_valid<=0.
  - Any capture or handshake in the same cycle is discarded, and the capture's update_pc is not issued twice.
  - Next state:
    - DRAIN if a request is outstanding and mem_valid is low this cycle;
    - otherwise IDLE.
  - mem_req is never dropped mid-transaction.
- update_pc is forced 0 while reset is high. Outside a flush it is asserted only on a FETCH capture, exactly once per accepted fetch.
- Memory contract: one outstanding request at most; no address wrap handling is needed here (PC owns wrap 0x3FFF->0x0000).

## Timing
- Reset values: mem_req=0, mem_addr=0, instr=0, instr_addr=0, instr_valid=0, update_pc=0, state IDLE.
- Zero-wait memory:
  - cycle 0 IDLE issues;
  - cycle 1 mem_req=1, mem_valid=1, capture, update_pc=1;
  - cycle 2 instr_valid=1 and pc already incremented.
- Throughput is 1 instruction per 2 cycles at zero wait with instr_ready held high. N wait states add N cycles.
- After flush, the first request targets the jump address: pc is reloaded on the flush edge and sampled in IDLE the next cycle. Minimum flush-to-new-instr_valid is 3 cycles at zero wait.
- Reset assertion mid-FETCH clears all state immediately; the outstanding memory response is ignored.

## Test plan
- Reset, pc=0x0000, zero-wait memory returning 0x2805, instr_ready=1 -> instr_valid=1 with instr=0x2805/instr_addr=0x0000 at cycle 2; one update_pc pulse; fetches at 0x0000,0x0001,0x0002 every 2 cycles.
- Memory with 3 wait states -> mem_addr stable and mem_req high for 4 cycles; single update_pc on the mem_valid cycle; no duplicate capture.
- instr_ready low for 5 cycles in HOLD -> instr/instr_addr stable, no new mem_req, no update_pc; resumes fetching after instr_ready.
- flush during FETCH, 2 cycles before mem_valid, jump target 0x0123 -> DRAIN, stale data discarded, instr_valid stays 0; next mem_addr=0x0123; update_pc pulses exactly once, in the flush cycle.
- flush coincident with mem_valid -> data discarded, update_pc=1 once, next state IDLE, next fetch at jump target.
- fetch_enable dropped mid-FETCH -> outstanding fetch completes into HOLD; after instr_ready go IDLE with mem_req=0. Reset asserted mid-FETCH -> all outputs 0 asynchronously.
